// File: rtl/toy_bus_pkg.sv
// Shared definitions for the toy debug bus: opcode encoding and the
// helper that decides which requests need an entry in the tracking FIFO.
package toy_bus_pkg;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } opcode_e;

  localparam int unsigned OST_DEPTH_MIN = 32'd1;

  // Reads always come back with data; writes are only tracked when the node
  // is configured to answer them locally.
  function automatic logic needs_track(input logic opcode, input logic wr_ack_en);
    return (opcode == OP_RD) || wr_ack_en;
  endfunction

endpackage

// File: rtl/toy_bus_sync_fifo.sv
// Small synchronous FIFO with occupancy count. Push while full and pop while
// empty are ignored, so callers may drive them unconditionally.
module toy_bus_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == CNT_W'(0));
  assign count_o   = cnt_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/toy_bus_dbg_mst_node_ost.sv
// Debug-master bus node: forwards requests downstream, tracks outstanding
// transactions in order, and returns registered acks to the master.
module toy_bus_dbg_mst_node_ost
  import toy_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned OST_DEPTH = 4,
  parameter int unsigned NODE_ID   = 0,
  parameter int unsigned WR_ACK_EN = 0,
  localparam int unsigned CNT_W    = $clog2(OST_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in0_req_vld,
  output logic                in0_req_rdy,
  input  logic [ADDR_W-1:0]   in0_req_addr,
  input  logic [DATA_W/8-1:0] in0_req_strb,
  input  logic [DATA_W-1:0]   in0_req_data,
  input  logic                in0_req_opcode,
  input  logic [ID_W-1:0]     in0_req_src_id,
  input  logic [ID_W-1:0]     in0_req_tgt_id,
  output logic                in0_ack_vld,
  input  logic                in0_ack_rdy,
  output logic                in0_ack_opcode,
  output logic [DATA_W-1:0]   in0_ack_data,
  output logic [ID_W-1:0]     in0_ack_src_id,
  output logic [ID_W-1:0]     in0_ack_tgt_id,
  output logic                out0_req_vld,
  input  logic                out0_req_rdy,
  output logic [ADDR_W-1:0]   out0_req_addr,
  output logic [DATA_W-1:0]   out0_req_data,
  output logic [DATA_W/8-1:0] out0_req_strb,
  output logic                out0_req_opcode,
  input  logic                out0_ack_vld,
  output logic                out0_ack_rdy,
  input  logic [DATA_W-1:0]   out0_ack_data,
  output logic [CNT_W-1:0]    ost_cnt,
  output logic                stray_ack_err
);

  typedef struct packed {
    opcode_e         opcode;
    logic [ID_W-1:0] src_id;
  } trk_entry_t;

  typedef struct packed {
    opcode_e           opcode;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
  } ack_pld_t;

  localparam logic            WR_ACK_ON = (WR_ACK_EN != 0);
  localparam logic [ID_W-1:0] NODE_ID_V = ID_W'(NODE_ID);

  trk_entry_t push_entry_s;
  trk_entry_t head_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       track_s;
  logic       blocked_s;
  logic       push_s;
  logic       load_ok_s;
  logic       head_rd_s;
  logic       head_wr_s;
  logic       rd_pop_s;
  logic       wr_pop_s;
  logic       pop_s;
  logic       stray_s;
  logic       ack_vld_q, ack_vld_d;
  ack_pld_t   ack_pld_q, ack_pld_d;
  logic       stray_q, stray_d;
  logic       unused_s;

  // The target id of a request is routed downstream by address, not by this node.
  assign unused_s = ^in0_req_tgt_id;

  assign track_s   = needs_track(in0_req_opcode, WR_ACK_ON);
  assign blocked_s = track_s && fifo_full_s;

  assign out0_req_vld    = in0_req_vld && !blocked_s;
  assign in0_req_rdy     = out0_req_rdy && !blocked_s;
  assign out0_req_addr   = in0_req_addr;
  assign out0_req_data   = in0_req_data;
  assign out0_req_strb   = in0_req_strb;
  assign out0_req_opcode = in0_req_opcode;

  assign push_s              = out0_req_vld && out0_req_rdy && track_s;
  assign push_entry_s.opcode = opcode_e'(in0_req_opcode);
  assign push_entry_s.src_id = in0_req_src_id;

  toy_bus_sync_fifo #(
    .WIDTH ($bits(trk_entry_t)),
    .DEPTH (OST_DEPTH)
  ) u_trk_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (ost_cnt)
  );

  assign load_ok_s = !ack_vld_q || in0_ack_rdy;
  assign head_rd_s = !fifo_empty_s && (head_s.opcode == OP_RD);
  assign head_wr_s = !fifo_empty_s && (head_s.opcode == OP_WR) && WR_ACK_ON;
  assign rd_pop_s  = head_rd_s && load_ok_s && out0_ack_vld;
  assign wr_pop_s  = head_wr_s && load_ok_s;
  assign pop_s     = rd_pop_s || wr_pop_s;
  assign stray_s   = fifo_empty_s && out0_ack_vld;

  // Downstream ack ready: swallow anything while empty, else only a read head with room.
  always_comb begin
    out0_ack_rdy = 1'b0;
    if (fifo_empty_s) begin
      out0_ack_rdy = 1'b1;
    end else begin
      out0_ack_rdy = head_rd_s && load_ok_s;
    end
  end

  // Ack register next-state: load on pop, drop on acceptance, otherwise hold.
  always_comb begin
    ack_vld_d = ack_vld_q;
    ack_pld_d = ack_pld_q;
    if (pop_s) begin
      ack_vld_d        = 1'b1;
      ack_pld_d.opcode = head_s.opcode;
      ack_pld_d.data   = rd_pop_s ? out0_ack_data : '0;
      ack_pld_d.src_id = NODE_ID_V;
      ack_pld_d.tgt_id = head_s.src_id;
    end else if (in0_ack_rdy) begin
      ack_vld_d = 1'b0;
    end else begin
      ack_vld_d = ack_vld_q;
    end
  end

  // Sticky stray-ack flag next-state.
  always_comb begin
    stray_d = stray_q;
    if (stray_s) begin
      stray_d = 1'b1;
    end else begin
      stray_d = stray_q;
    end
  end

  // Ack output and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_vld_q <= 1'b0;
      ack_pld_q <= '0;
      stray_q   <= 1'b0;
    end else begin
      ack_vld_q <= ack_vld_d;
      ack_pld_q <= ack_pld_d;
      stray_q   <= stray_d;
    end
  end

  assign in0_ack_vld    = ack_vld_q;
  assign in0_ack_opcode = ack_pld_q.opcode;
  assign in0_ack_data   = ack_pld_q.data;
  assign in0_ack_src_id = ack_pld_q.src_id;
  assign in0_ack_tgt_id = ack_pld_q.tgt_id;
  assign stray_ack_err  = stray_q;

endmodule

// File: tb/tb_toy_bus_dbg_mst_node_ost.sv
// Directed bench: stimulus pushes expected acks into a scoreboard queue and a
// separate monitor compares every accepted upstream ack against it.
module tb_toy_bus_dbg_mst_node_ost;

  localparam int NODE_ID = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_req_vld = 1'b0;
  logic        in0_req_rdy;
  logic [31:0] in0_req_addr = 32'h0;
  logic [3:0]  in0_req_strb = 4'h0;
  logic [31:0] in0_req_data = 32'h0;
  logic        in0_req_opcode = 1'b0;
  logic [3:0]  in0_req_src_id = 4'h0;
  logic [3:0]  in0_req_tgt_id = 4'h0;
  logic        in0_ack_vld;
  logic        in0_ack_rdy = 1'b1;
  logic        in0_ack_opcode;
  logic [31:0] in0_ack_data;
  logic [3:0]  in0_ack_src_id;
  logic [3:0]  in0_ack_tgt_id;
  logic        out0_req_vld;
  logic        out0_req_rdy = 1'b1;
  logic [31:0] out0_req_addr;
  logic [31:0] out0_req_data;
  logic [3:0]  out0_req_strb;
  logic        out0_req_opcode;
  logic        out0_ack_vld = 1'b0;
  logic        out0_ack_rdy;
  logic [31:0] out0_ack_data = 32'h0;
  logic [2:0]  ost_cnt;
  logic        stray_ack_err;

  typedef struct packed {
    logic        op;
    logic [31:0] data;
    logic [3:0]  tgt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  toy_bus_dbg_mst_node_ost #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .OST_DEPTH(4),
    .NODE_ID(NODE_ID), .WR_ACK_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy),
    .in0_req_addr(in0_req_addr), .in0_req_strb(in0_req_strb),
    .in0_req_data(in0_req_data), .in0_req_opcode(in0_req_opcode),
    .in0_req_src_id(in0_req_src_id), .in0_req_tgt_id(in0_req_tgt_id),
    .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(in0_ack_rdy),
    .in0_ack_opcode(in0_ack_opcode), .in0_ack_data(in0_ack_data),
    .in0_ack_src_id(in0_ack_src_id), .in0_ack_tgt_id(in0_ack_tgt_id),
    .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy),
    .out0_req_addr(out0_req_addr), .out0_req_data(out0_req_data),
    .out0_req_strb(out0_req_strb), .out0_req_opcode(out0_req_opcode),
    .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy),
    .out0_ack_data(out0_ack_data),
    .ost_cnt(ost_cnt), .stray_ack_err(stray_ack_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic op, input logic [31:0] data, input logic [3:0] tgt);
    exp_t e;
    e.op = op; e.data = data; e.tgt = tgt;
    exp_q.push_back(e);
  endtask

  // Issue one upstream request and hold it until it is handshaken (bounded).
  task automatic do_req(input logic op, input logic [31:0] addr, input logic [3:0] src,
                        input logic [31:0] wd);
    int n;
    bit done;
    in0_req_vld = 1'b1; in0_req_opcode = op; in0_req_addr = addr;
    in0_req_src_id = src; in0_req_tgt_id = 4'hE; in0_req_data = wd; in0_req_strb = 4'hF;
    n = 0; done = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in0_req_rdy && out0_req_vld && out0_req_rdy) done = 1'b1;
      else n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL req_timeout actual=no_handshake required=handshake src=%0d", src);
    end else begin
      chk("req_addr_pass", out0_req_addr, addr);
      chk("req_op_pass", out0_req_opcode, op);
      chk("req_data_pass", out0_req_data, wd);
    end
    @(posedge clk);
    #1;
    in0_req_vld = 1'b0;
  endtask

  // Present one downstream ack and hold it until accepted (bounded).
  task automatic send_dack(input logic [31:0] d);
    int n;
    bit done;
    out0_ack_vld = 1'b1; out0_ack_data = d;
    n = 0; done = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (out0_ack_rdy) done = 1'b1;
      else n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL dack_timeout actual=not_ready required=ready data=%0h", d);
    end
    @(posedge clk);
    #1;
    out0_ack_vld = 1'b0;
  endtask

  // Monitor: compare each ack the master accepts against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && in0_ack_vld && in0_ack_rdy) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack actual=tgt%0d data=%0h required=none",
                 in0_ack_tgt_id, in0_ack_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_opcode", in0_ack_opcode, e.op);
        chk("ack_data", in0_ack_data, e.data);
        chk("ack_tgt_id", in0_ack_tgt_id, e.tgt);
        chk("ack_src_id", in0_ack_src_id, 4'(NODE_ID));
      end
    end
  end

  initial begin
    cycles(3);
    rst = 1'b0;
    #1;
    chk("rst_ost_cnt", ost_cnt, 3'd0);
    chk("rst_ack_vld", in0_ack_vld, 1'b0);
    chk("rst_ack_data", in0_ack_data, 32'h0);
    chk("rst_stray", stray_ack_err, 1'b0);

    // Downstream request backpressure propagates upstream combinationally.
    out0_req_rdy = 1'b0; in0_req_vld = 1'b1; in0_req_opcode = 1'b0;
    #1;
    chk("bp_in0_req_rdy", in0_req_rdy, 1'b0);
    chk("bp_out0_req_vld", out0_req_vld, 1'b1);
    in0_req_vld = 1'b0; out0_req_rdy = 1'b1;
    cycles(1);

    // Single read.
    push_exp(1'b0, 32'hDEADBEEF, 4'd3);
    do_req(1'b0, 32'h100, 4'd3, 32'h0);
    chk("single_cnt1", ost_cnt, 3'd1);
    cycles(2);
    chk("single_pre_vld", in0_ack_vld, 1'b0);
    send_dack(32'hDEADBEEF);
    chk("single_vld_lat1", in0_ack_vld, 1'b1);
    chk("single_cnt0", ost_cnt, 3'd0);
    cycles(2);

    // Depth limit with stalled downstream acks.
    push_exp(1'b0, 32'hA0000001, 4'd1);
    push_exp(1'b0, 32'hA0000002, 4'd2);
    push_exp(1'b0, 32'hA0000003, 4'd3);
    push_exp(1'b0, 32'hA0000004, 4'd4);
    push_exp(1'b0, 32'hA0000005, 4'd5);
    for (int i = 1; i <= 4; i++) do_req(1'b0, 32'h200 + 32'(i), 4'(i), 32'h0);
    chk("depth_cnt4", ost_cnt, 3'd4);
    in0_req_vld = 1'b1; in0_req_opcode = 1'b0; in0_req_addr = 32'h205; in0_req_src_id = 4'd5;
    @(negedge clk);
    chk("full_in0_rdy", in0_req_rdy, 1'b0);
    chk("full_out0_vld", out0_req_vld, 1'b0);
    out0_ack_vld = 1'b1; out0_ack_data = 32'hA0000001;
    #1;
    chk("full_dack_rdy", out0_ack_rdy, 1'b1);
    @(posedge clk); #1;
    out0_ack_vld = 1'b0;
    chk("full_pop_cnt3", ost_cnt, 3'd3);
    chk("full_rdy_back", in0_req_rdy, 1'b1);
    @(posedge clk); #1;
    in0_req_vld = 1'b0;
    chk("fifth_cnt4", ost_cnt, 3'd4);
    send_dack(32'hA0000002);
    send_dack(32'hA0000003);
    send_dack(32'hA0000004);
    send_dack(32'hA0000005);
    cycles(2);
    chk("depth_drain_cnt", ost_cnt, 3'd0);

    // Local write ack between two reads.
    push_exp(1'b0, 32'h12345678, 4'd1);
    push_exp(1'b1, 32'h0, 4'd2);
    push_exp(1'b0, 32'h9ABCDEF0, 4'd3);
    do_req(1'b0, 32'h300, 4'd1, 32'h0);
    do_req(1'b1, 32'h304, 4'd2, 32'h55AA55AA);
    do_req(1'b0, 32'h308, 4'd3, 32'h0);
    chk("wr_cnt3", ost_cnt, 3'd3);
    send_dack(32'h12345678);
    chk("wr_head_blocks_dack", out0_ack_rdy, 1'b0);
    cycles(1);
    chk("wr_local_pop_cnt1", ost_cnt, 3'd1);
    send_dack(32'h9ABCDEF0);
    cycles(2);

    // Upstream ack backpressure with two reads pending.
    push_exp(1'b0, 32'h11111111, 4'd6);
    push_exp(1'b0, 32'h22222222, 4'd7);
    in0_ack_rdy = 1'b0;
    do_req(1'b0, 32'h400, 4'd6, 32'h0);
    do_req(1'b0, 32'h404, 4'd7, 32'h0);
    send_dack(32'h11111111);
    out0_ack_vld = 1'b1; out0_ack_data = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld", in0_ack_vld, 1'b1);
      chk("hold_data", in0_ack_data, 32'h11111111);
      chk("hold_dack_rdy", out0_ack_rdy, 1'b0);
    end
    @(posedge clk); #1;
    in0_ack_rdy = 1'b1;
    @(posedge clk); #1;
    out0_ack_vld = 1'b0;
    chk("b2b_vld", in0_ack_vld, 1'b1);
    chk("b2b_data", in0_ack_data, 32'h22222222);
    cycles(2);

    // Stray downstream ack.
    out0_ack_vld = 1'b1; out0_ack_data = 32'h0BADF00D;
    #1;
    chk("stray_rdy", out0_ack_rdy, 1'b1);
    @(posedge clk); #1;
    out0_ack_vld = 1'b0;
    chk("stray_set", stray_ack_err, 1'b1);
    chk("stray_no_ack", in0_ack_vld, 1'b0);
    cycles(3);
    chk("stray_sticky", stray_ack_err, 1'b1);

    // Reset with two reads outstanding; those acks are discarded.
    do_req(1'b0, 32'h500, 4'd8, 32'h0);
    do_req(1'b0, 32'h504, 4'd9, 32'h0);
    chk("pre_rst_cnt", ost_cnt, 3'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_cnt", ost_cnt, 3'd0);
    chk("mid_rst_vld", in0_ack_vld, 1'b0);
    chk("mid_rst_stray", stray_ack_err, 1'b0);
    send_dack(32'hBAD0BAD0);
    chk("late_ack_stray", stray_ack_err, 1'b1);
    chk("late_ack_no_vld", in0_ack_vld, 1'b0);
    push_exp(1'b0, 32'hCAFEF00D, 4'd10);
    do_req(1'b0, 32'h600, 4'd10, 32'h0);
    send_dack(32'hCAFEF00D);
    chk("post_rst_vld", in0_ack_vld, 1'b1);
    cycles(4);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
